directory_msi: RTL

DIRECTORY_MSI -- requirements
Module: directory_msi

---
 rtl/directory_msi.sv | 352 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/directory_msi.sv
// Two-cache MSI directory with 16 blocks, each holding a state, a presence vector and a memory word.
// Optional DIR_STATS_EN adds saturating read-miss/write-miss counters.
module directory_msi (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ReqValid,
    output logic       ReqReady,
    input  logic [1:0] ReqOp,
    input  logic       ReqProc,
    input  logic [3:0] ReqAddr,
    input  logic [3:0] ReqData,
    output logic       CohValid,
    output logic [1:0] CohOp,
    output logic       CohProc,
    output logic [3:0] CohAddr,
    input  logic       CohAck,
    input  logic [3:0] CohData,
    output logic       RespValid,
    input  logic       RespReady,
    output logic       RespProc,
    output logic [3:0] RespAddr,
    output logic [3:0] RespData,
    output logic [1:0] RespGrant
`ifdef DIR_STATS_EN
    ,
    output logic [7:0] ReadMissCnt,
    output logic [7:0] WriteMissCnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_COH,
        S_REPLY
    } fsm_e;

    typedef enum logic [1:0] {
        D_U = 2'b00,
        D_S = 2'b01,
        D_M = 2'b10
    } dst_e;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_WB   = 2'b10;

    localparam logic [1:0] C_INV   = 2'b00;
    localparam logic [1:0] C_FETCH = 2'b01;
    localparam logic [1:0] C_FINV  = 2'b10;

    localparam logic [1:0] G_WB    = 2'b00;
    localparam logic [1:0] G_S     = 2'b01;
    localparam logic [1:0] G_M     = 2'b10;

    fsm_e       state_q, state_d;
    logic       phase_q, phase_d;
    logic [1:0] op_q, op_d;
    logic       proc_q, proc_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] data_q, data_d;

    logic       coh_valid_q, coh_valid_d;
    logic [1:0] coh_op_q, coh_op_d;
    logic       coh_proc_q, coh_proc_d;
    logic [3:0] coh_addr_q, coh_addr_d;

    logic       resp_valid_q, resp_valid_d;
    logic       resp_proc_q, resp_proc_d;
    logic [3:0] resp_addr_q, resp_addr_d;
    logic [3:0] resp_data_q, resp_data_d;
    logic [1:0] resp_grant_q, resp_grant_d;

    dst_e       dir_st_q [16];
    logic [1:0] dir_pr_q [16];
    logic [3:0] mem_q    [16];

    dst_e       cur_st;
    logic [1:0] cur_pr;
    logic [3:0] cur_mem;
    logic [1:0] p_bit;
    logic [1:0] q_bit;
    logic       own_m;
    logic       other_m;
    logic       other_s;

    logic       commit;
    dst_e       new_st;
    logic [1:0] new_pr;
    logic       mem_we;
    logic [3:0] mem_wd;

    logic       do_reply;
    logic [3:0] reply_data;
    logic [1:0] reply_grant;
    logic       do_coh;
    logic [1:0] coh_kind;

    assign ReqReady  = (state_q == S_IDLE) && !Reset;
    assign CohValid  = coh_valid_q;
    assign CohOp     = coh_op_q;
    assign CohProc   = coh_proc_q;
    assign CohAddr   = coh_addr_q;
    assign RespValid = resp_valid_q;
    assign RespProc  = resp_proc_q;
    assign RespAddr  = resp_addr_q;
    assign RespData  = resp_data_q;
    assign RespGrant = resp_grant_q;

    // Directory entry of the latched block, seen from the requester's side
    always_comb begin
        cur_st  = dir_st_q[addr_q];
        cur_pr  = dir_pr_q[addr_q];
        cur_mem = mem_q[addr_q];
        p_bit   = proc_q ? 2'b10 : 2'b01;
        q_bit   = ~p_bit;
        own_m   = (cur_st == D_M) && ((cur_pr & p_bit) != 2'b00);
        other_m = (cur_st == D_M) && ((cur_pr & q_bit) != 2'b00);
        other_s = (cur_st == D_S) && ((cur_pr & q_bit) != 2'b00);
    end

    // Protocol decision: next FSM state, directory commit and message launch
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        op_d        = op_q;
        proc_d      = proc_q;
        addr_d      = addr_q;
        data_d      = data_q;
        commit      = 1'b0;
        new_st      = cur_st;
        new_pr      = cur_pr;
        mem_we      = 1'b0;
        mem_wd      = cur_mem;
        do_reply    = 1'b0;
        reply_data  = cur_mem;
        reply_grant = G_WB;
        do_coh      = 1'b0;
        coh_kind    = C_INV;

        unique case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    op_d    = ReqOp;
                    proc_d  = ReqProc;
                    addr_d  = ReqAddr;
                    data_d  = ReqData;
                    phase_d = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    unique case (op_q)
                        OP_RD: begin
                            if (other_m) begin
                                do_coh   = 1'b1;
                                coh_kind = C_FETCH;
                            end else begin
                                commit      = 1'b1;
                                new_st      = D_S;
                                new_pr      = (cur_st == D_M) ? p_bit : (cur_pr | p_bit);
                                do_reply    = 1'b1;
                                reply_grant = G_S;
                            end
                        end
                        OP_WR: begin
                            if (other_s) begin
                                do_coh   = 1'b1;
                                coh_kind = C_INV;
                            end else if (other_m) begin
                                do_coh   = 1'b1;
                                coh_kind = C_FINV;
                            end else begin
                                commit      = 1'b1;
                                new_st      = D_M;
                                new_pr      = p_bit;
                                do_reply    = 1'b1;
                                reply_grant = G_M;
                            end
                        end
                        OP_WB: begin
                            do_reply    = 1'b1;
                            reply_grant = G_WB;
                            if (own_m) begin
                                commit     = 1'b1;
                                new_st     = D_U;
                                new_pr     = 2'b00;
                                mem_we     = 1'b1;
                                mem_wd     = data_q;
                                reply_data = data_q;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_COH: begin
                if (CohAck) begin
                    commit      = 1'b1;
                    do_reply    = 1'b1;
                    unique case (coh_op_q)
                        C_FETCH: begin
                            mem_we      = 1'b1;
                            mem_wd      = CohData;
                            new_st      = D_S;
                            new_pr      = 2'b11;
                            reply_data  = CohData;
                            reply_grant = G_S;
                        end
                        C_INV: begin
                            new_st      = D_M;
                            new_pr      = p_bit;
                            reply_grant = G_M;
                        end
                        default: begin
                            mem_we      = 1'b1;
                            mem_wd      = CohData;
                            new_st      = D_M;
                            new_pr      = p_bit;
                            reply_data  = CohData;
                            reply_grant = G_M;
                        end
                    endcase
                end
            end
            S_REPLY: begin
                if (RespReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_reply) state_d = S_REPLY;
        if (do_coh)   state_d = S_COH;
    end

    // Coherence and response message registers, held until their handshake
    always_comb begin
        coh_valid_d  = coh_valid_q;
        coh_op_d     = coh_op_q;
        coh_proc_d   = coh_proc_q;
        coh_addr_d   = coh_addr_q;
        resp_valid_d = resp_valid_q;
        resp_proc_d  = resp_proc_q;
        resp_addr_d  = resp_addr_q;
        resp_data_d  = resp_data_q;
        resp_grant_d = resp_grant_q;

        if (do_coh) begin
            coh_valid_d = 1'b1;
            coh_op_d    = coh_kind;
            coh_proc_d  = ~proc_q;
            coh_addr_d  = addr_q;
        end else if (state_q == S_COH && CohAck) begin
            coh_valid_d = 1'b0;
        end

        if (do_reply) begin
            resp_valid_d = 1'b1;
            resp_proc_d  = proc_q;
            resp_addr_d  = addr_q;
            resp_data_d  = reply_data;
            resp_grant_d = reply_grant;
        end else if (state_q == S_REPLY && RespReady) begin
            resp_valid_d = 1'b0;
        end
    end

    // Control, request latch and message registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            phase_q      <= 1'b0;
            op_q         <= 2'b00;
            proc_q       <= 1'b0;
            addr_q       <= 4'h0;
            data_q       <= 4'h0;
            coh_valid_q  <= 1'b0;
            coh_op_q     <= 2'b00;
            coh_proc_q   <= 1'b0;
            coh_addr_q   <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_proc_q  <= 1'b0;
            resp_addr_q  <= 4'h0;
            resp_data_q  <= 4'h0;
            resp_grant_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            op_q         <= op_d;
            proc_q       <= proc_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            coh_valid_q  <= coh_valid_d;
            coh_op_q     <= coh_op_d;
            coh_proc_q   <= coh_proc_d;
            coh_addr_q   <= coh_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_proc_q  <= resp_proc_d;
            resp_addr_q  <= resp_addr_d;
            resp_data_q  <= resp_data_d;
            resp_grant_q <= resp_grant_d;
        end
    end

    // Directory and memory array; reset restores identity memory contents
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                dir_st_q[i] <= D_U;
                dir_pr_q[i] <= 2'b00;
                mem_q[i]    <= 4'(i);
            end
        end else if (commit) begin
            dir_st_q[addr_q] <= new_st;
            dir_pr_q[addr_q] <= new_pr;
            if (mem_we) mem_q[addr_q] <= mem_wd;
        end
    end

`ifdef DIR_STATS_EN
    logic       accept;
    logic [7:0] rd_cnt_q, rd_cnt_d;
    logic [7:0] wr_cnt_q, wr_cnt_d;

    assign accept       = (state_q == S_IDLE) && ReqValid;
    assign ReadMissCnt  = rd_cnt_q;
    assign WriteMissCnt = wr_cnt_q;

    // Saturating miss counters bumped on request acceptance
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (accept && ReqOp == OP_RD && rd_cnt_q != 8'hFF) rd_cnt_d = rd_cnt_q + 8'd1;
        if (accept && ReqOp == OP_WR && wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
    end

    // Counter registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_cnt_q <= 8'h00;
            wr_cnt_q <= 8'h00;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end
`endif

endmodule
